// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types and scan address table for the RTC bus sequencer
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADR,
        GAP,
        DAT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_SCAN
    } op_e;

    localparam logic [2:0] SCAN_LAST = 3'd5;

    // seconds, minutes, hours, day, month, year
    function automatic logic [7:0] scan_addr(input logic [2:0] idx);
        logic [7:0] addr;
        case (idx)
            3'd0:    addr = 8'h21;
            3'd1:    addr = 8'h22;
            3'd2:    addr = 8'h23;
            3'd3:    addr = 8'h24;
            3'd4:    addr = 8'h25;
            3'd5:    addr = 8'h26;
            default: addr = 8'h21;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable 8-bit down counter; expire flags the last cycle of a bus phase
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // A load of N yields N cycles of count N..1; the final one is the expiring cycle.
    assign expire = (count == 8'd1);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed address/data bus sequencer; RTC_READ_SCAN_EN adds periodic register scan
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PH        = 10,
    parameter int unsigned SCAN_PERIOD = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic [7:0] rd_data,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       A_D,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       busy
`ifdef RTC_READ_SCAN_EN
    ,
    output logic [7:0] scan_data,
    output logic [2:0] scan_idx,
    output logic       scan_valid
`endif
);

    if (T_PH < 2 || T_PH > 255 || SCAN_PERIOD < 1) begin : g_param_check
        $error("rtc_bus_sequencer: T_PH must be 2..255 and SCAN_PERIOD at least 1");
    end

    localparam logic [7:0] T_LOAD = 8'(T_PH);

    state_e     state;
    op_e        op;
    logic [7:0] data_q;
    logic       scan_req;
    logic       grant;
    logic       tmr_load;
    logic       tmr_expire;

`ifdef RTC_READ_SCAN_EN
    localparam int unsigned SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tick;
    logic              scan_pending;
    logic [2:0]        scan_idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= 1'b0;
            if (scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
                scan_cnt  <= '0;
                scan_tick <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign scan_req = scan_pending;
`else
    assign scan_req = 1'b0;
`endif

    assign grant    = (state == IDLE) && (wr_req || rd_req || scan_req);
    assign tmr_load = grant || (tmr_expire && (state == ADR || state == GAP));

    rtc_phase_timer u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (T_LOAD),
        .expire   (tmr_expire)
    );

    // Strobes are assigned on state transitions so every bus output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op      <= OP_WR;
            data_q  <= 8'd0;
            A_D     <= 1'b1;
            CS      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= 8'd0;
            busy    <= 1'b0;
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            rd_data <= 8'd0;
`ifdef RTC_READ_SCAN_EN
            scan_pending <= 1'b0;
            scan_idx_q   <= 3'd0;
            scan_data    <= 8'd0;
            scan_idx     <= 3'd0;
            scan_valid   <= 1'b0;
`endif
        end else begin
            wr_ack <= 1'b0;
            rd_ack <= 1'b0;
`ifdef RTC_READ_SCAN_EN
            scan_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= ADR;
                        busy  <= 1'b1;
                        A_D   <= 1'b0;
                        CS    <= 1'b0;
                        WR    <= 1'b0;
                        RD    <= 1'b1;
                        ad_oe <= 1'b1;
                        if (wr_req) begin
                            op     <= OP_WR;
                            ad_out <= wr_addr;
                            data_q <= wr_data;
                        end else if (rd_req) begin
                            op     <= OP_RD;
                            ad_out <= rd_addr;
                        end
`ifdef RTC_READ_SCAN_EN
                        else begin
                            op     <= OP_SCAN;
                            ad_out <= scan_addr(scan_idx_q);
                        end
`endif
                    end
                end
                ADR: begin
                    if (tmr_expire) begin
                        state  <= GAP;
                        A_D    <= 1'b1;
                        CS     <= 1'b1;
                        WR     <= 1'b1;
                        RD     <= 1'b1;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'd0;
                    end
                end
                GAP: begin
                    if (tmr_expire) begin
                        state <= DAT;
                        CS    <= 1'b0;
                        if (op == OP_WR) begin
                            WR     <= 1'b0;
                            ad_oe  <= 1'b1;
                            ad_out <= data_q;
                        end else begin
                            RD <= 1'b0;
                        end
                    end
                end
                DAT: begin
                    if (tmr_expire) begin
                        state  <= DONE;
                        CS     <= 1'b1;
                        RD     <= 1'b1;
                        WR     <= 1'b1;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'd0;
                        case (op)
                            OP_WR: wr_ack <= 1'b1;
                            OP_RD: begin
                                rd_ack  <= 1'b1;
                                rd_data <= ad_in;
                            end
`ifdef RTC_READ_SCAN_EN
                            OP_SCAN: begin
                                scan_valid <= 1'b1;
                                scan_data  <= ad_in;
                                scan_idx   <= scan_idx_q;
                                if (scan_idx_q == SCAN_LAST) begin
                                    scan_idx_q   <= 3'd0;
                                    scan_pending <= 1'b0;
                                end else begin
                                    scan_idx_q <= scan_idx_q + 3'd1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
`ifdef RTC_READ_SCAN_EN
            // A tick coinciding with the end of a sweep re-arms rather than being dropped.
            if (scan_tick) begin
                scan_pending <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer (scan checks when RTC_READ_SCAN_EN is defined)
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

    localparam int T   = 4;
    localparam int SP  = 100;
    localparam int OPW = 0;
    localparam int OPR = 1;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       wr_req  = 1'b0;
    logic [7:0] wr_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       rd_req  = 1'b0;
    logic [7:0] rd_addr = 8'd0;
    logic [7:0] ad_in   = 8'd0;
    logic       wr_ack, rd_ack, ad_oe, A_D, CS, RD, WR, busy;
    logic [7:0] rd_data, ad_out;
`ifdef RTC_READ_SCAN_EN
    logic [7:0] scan_data;
    logic [2:0] scan_idx;
    logic       scan_valid;
    int         sc_idx[$];
    int         sc_data[$];
    int         sc_cyc[$];
`endif

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] rtc_mem [256];
    logic [7:0] shadow  [256];
    logic [7:0] lat_addr = 8'd0;
    logic [7:0] last_rd  = 8'd0;

    rtc_bus_sequencer #(.T_PH(T), .SCAN_PERIOD(SP)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .ad_in      (ad_in),
        .A_D        (A_D),
        .CS         (CS),
        .RD         (RD),
        .WR         (WR),
        .busy       (busy)
`ifdef RTC_READ_SCAN_EN
        ,
        .scan_data  (scan_data),
        .scan_idx   (scan_idx),
        .scan_valid (scan_valid)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC chip: latches the address phase, stores write data, drives read data only while RD is low.
    initial forever begin
        @(negedge clk);
        if (!CS && !A_D) lat_addr = ad_out;
        if (!CS && A_D && !WR && ad_oe) rtc_mem[lat_addr] = ad_out;
        ad_in = (!CS && A_D && !RD) ? rtc_mem[lat_addr] : ~rtc_mem[lat_addr];
    end

`ifdef RTC_READ_SCAN_EN
    initial forever begin
        @(negedge clk);
        if (scan_valid === 1'b1) begin
            sc_idx.push_back(int'(scan_idx));
            sc_data.push_back(int'(scan_data));
            sc_cyc.push_back(cyc);
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {busy, A_D, CS, RD, WR, ad_oe} k cycles after the grant cycle.
    function automatic logic [5:0] exp_bus(input int op, input int k);
        int ph;
        if (k > 3 * T) ph = 4;
        else           ph = (k - 1) / T + 1;
        case (ph)
            1:       return 6'b1_0_0_1_0_1;
            2:       return 6'b1_1_1_1_1_0;
            3:       return (op == OPW) ? 6'b1_1_0_1_0_1 : 6'b1_1_0_0_1_0;
            default: return 6'b1_1_1_1_1_0;
        endcase
    endfunction

    // Raises the request in an idle cycle (cycle 0) and checks every following cycle through DONE.
    task automatic follow(input int op, input logic [7:0] a, input logic [7:0] d, input int drop_at,
                          input int abort_at, input bit with_rd, output int ack_cyc);
        int n;
        ack_cyc = -1;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            check("idle_wait", {31'd0, busy}, 32'd0);
            return;
        end
        if (op == OPW) begin
            wr_addr = a;
            wr_data = d;
            wr_req  = 1'b1;
            shadow[a] = d;
            if (with_rd) rd_req = 1'b1;
        end else begin
            rd_addr = a;
            rd_req  = 1'b1;
        end
        for (int k = 1; k <= 3 * T + 1; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_bus", {busy, A_D, CS, RD, WR, ad_oe, wr_ack, rd_ack}, 8'b0_1111_0_00);
                check("abort_rd_data", rd_data, 8'd0);
                return;
            end
            check($sformatf("bus op=%0d k=%0d", op, k), {busy, A_D, CS, RD, WR, ad_oe}, exp_bus(op, k));
            check($sformatf("acks op=%0d k=%0d", op, k), {wr_ack, rd_ack},
                  (k == 3 * T + 1) ? ((op == OPW) ? 2'b10 : 2'b01) : 2'b00);
            if (k <= T) check($sformatf("adr_ad_out k=%0d", k), ad_out, a);
            if (op == OPW && k > 2 * T && k <= 3 * T) check($sformatf("dat_ad_out k=%0d", k), ad_out, d);
            if (k == 3 * T + 1) begin
                if (op == OPR) begin
                    check("rd_data", rd_data, shadow[a]);
                    last_rd = shadow[a];
                end else begin
                    check("rd_data_hold", rd_data, last_rd);
                end
                ack_cyc = cyc;
            end
            if (k == drop_at || k == 3 * T + 1) begin
                if (op == OPW) wr_req = 1'b0;
                else           rd_req = 1'b0;
            end
        end
    endtask

    initial begin
        int c1, c2, n, drop, op;
        bit saw;
        logic [7:0] a, d, ar;

        for (int i = 0; i < 256; i++) begin
            rtc_mem[i] = 8'($urandom);
            shadow[i]  = rtc_mem[i];
        end
        for (int i = 0; i < 6; i++) begin
            rtc_mem[8'h21 + i] = 8'(8'h80 + 16 * i + $urandom_range(0, 15));
            shadow[8'h21 + i]  = rtc_mem[8'h21 + i];
        end

        repeat (3) @(negedge clk);
        check("reset_bus", {busy, A_D, CS, RD, WR, ad_oe, wr_ack, rd_ack}, 8'b0_1111_0_00);
        check("reset_ad_out", ad_out, 8'd0);
        check("reset_rd_data", rd_data, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, A_D, CS, RD, WR, ad_oe}, 6'b0_1111_0);

        follow(OPW, 8'h21, 8'h45, 0, 0, 1'b0, c1);

        rtc_mem[8'h23] = 8'h12;
        shadow[8'h23]  = 8'h12;
        follow(OPR, 8'h23, 8'h00, 0, 0, 1'b0, c2);

        a  = 8'($urandom);
        d  = 8'($urandom);
        ar = 8'($urandom);
        rd_addr = ar;
        follow(OPW, a, d, 0, 0, 1'b1, c1);
        follow(OPR, ar, 8'h00, 0, 0, 1'b0, c2);
        check("wr_then_rd_gap", c2 - c1, 3 * T + 2);

        a = 8'($urandom_range(8'h40, 8'hff));
        d = 8'($urandom);
        follow(OPW, a, d, 0, 2 * T + 2, 1'b0, c1);
        repeat (2) @(negedge clk);
        wr_req = 1'b0;
        reset  = 1'b1;
        last_rd = 8'd0;
        saw = 1'b0;
        repeat (3 * T + 4) begin
            @(negedge clk);
            if (wr_ack === 1'b1) saw = 1'b1;
        end
        check("no_ack_after_abort", {31'd0, saw}, 32'd0);
        follow(OPW, a, d, 0, 0, 1'b0, c1);
        follow(OPR, a, 8'h00, 0, 0, 1'b0, c2);

        for (int i = 0; i < 10; i++) begin
            op   = int'($urandom_range(0, 1));
            a    = 8'($urandom);
            d    = 8'($urandom);
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 * T)) : 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            follow(op, a, d, drop, 0, 1'b0, c1);
        end

`ifdef RTC_READ_SCAN_EN
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_rd = 8'd0;
        sc_idx.delete();
        sc_data.delete();
        sc_cyc.delete();
        n = 0;
        while (sc_idx.size() < 2 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scan_first_two", sc_idx.size(), 2);
        d = 8'($urandom);
        follow(OPW, 8'h24, d, 0, 0, 1'b0, c1);
        n = 0;
        while (sc_idx.size() < 6 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("scan_count", sc_idx.size(), 6);
        if (sc_idx.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("scan_idx %0d", i), sc_idx[i], i);
                check($sformatf("scan_data %0d", i), sc_data[i], shadow[8'h21 + i]);
            end
            check("write_before_scan2", {31'd0, (c1 > sc_cyc[1] && c1 < sc_cyc[2])}, 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
